// File: rtl/rgb_pair_serializer_if.sv
// Pair-stream input and pixel-stream output of rgb_pair_serializer.
// slave is the serializer's view; master is the producer/sink side that drives the inputs.
interface rgb_pair_serializer_if #(
  parameter int ADDR_W = 8
);
  logic              VSYNC;
  logic              HSYNC;
  logic [7:0]        DATA_R0, DATA_G0, DATA_B0;
  logic [7:0]        DATA_R1, DATA_G1, DATA_B1;
  logic              PIX_READY;
  logic              PIX_VALID;
  logic [7:0]        PIX_R, PIX_G, PIX_B;
  logic [9:0]        PIX_X, PIX_Y;
  logic              PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF;
  logic [ADDR_W:0]   FIFO_LEVEL;
  logic              OVERFLOW;
  logic              FRAME_DONE;

  modport slave (
    input  VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, PIX_READY,
    output PIX_VALID, PIX_R, PIX_G, PIX_B, PIX_X, PIX_Y,
           PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF, FIFO_LEVEL, OVERFLOW, FRAME_DONE
  );

  modport master (
    output VSYNC, HSYNC, DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1, PIX_READY,
    input  PIX_VALID, PIX_R, PIX_G, PIX_B, PIX_X, PIX_Y,
           PIX_SOL, PIX_EOL, PIX_SOF, PIX_EOF, FIFO_LEVEL, OVERFLOW, FRAME_DONE
  );
endinterface

// File: rtl/rgb_pair_serializer.sv
// Pair FIFO plus 1-pixel/clock serializer with raster markers; pixel 0 is valid two edges after its push.
// Output is valid/ready and holds while stalled; input cannot be stalled, so pushes into a full FIFO are dropped and flagged.
module rgb_pair_serializer #(
  parameter int WIDTH      = 500,
  parameter int HEIGHT     = 500,
  parameter int FIFO_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  rgb_pair_serializer_if.slave  bus
);
  typedef enum logic [1:0] {S_EMPTY, S_PIX0, S_PIX1} state_t;

  localparam logic [9:0]      X_LAST   = 10'(WIDTH - 1);
  localparam logic [9:0]      Y_LAST   = 10'(HEIGHT - 1);
  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W + 1)'(FIFO_DEPTH);

  logic [47:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [47:0]       pair_q;
  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic              vsync_q, overflow_q, frame_done_q;

  logic              fifo_empty, fifo_full, push, pop, pix_vld, hs;
  logic              vsync_rise, at_sol, at_eol, at_sof, at_eof;
  logic [23:0]       pix;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (!fifo_empty) state_d = S_PIX0;
      S_PIX0:  if (bus.PIX_READY) state_d = S_PIX1;
      S_PIX1:  if (bus.PIX_READY) state_d = fifo_empty ? S_EMPTY : S_PIX0;
      default: state_d = S_EMPTY;
    endcase
  end

  // FSM outputs: the pop in S_PIX1 refills the output stage without a bubble
  always_comb begin
    pix_vld = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_EMPTY: pop = !fifo_empty;
      S_PIX0:  pix_vld = 1'b1;
      S_PIX1: begin
        pix_vld = 1'b1;
        pop     = bus.PIX_READY && !fifo_empty;
      end
      default: begin
        pix_vld = 1'b0;
        pop     = 1'b0;
      end
    endcase
  end

  assign hs   = pix_vld && bus.PIX_READY;
  assign push = bus.HSYNC && (!fifo_full || pop);
  assign level_d = level_q + (ADDR_W + 1)'(push) - (ADDR_W + 1)'(pop);

  // Resync only when nothing is in flight, so a running frame is never torn
  assign vsync_rise = bus.VSYNC && !vsync_q;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (hs) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end else if (vsync_rise && fifo_empty && state_q == S_EMPTY) begin
      x_d = '0;
      y_d = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= {bus.DATA_R0, bus.DATA_G0, bus.DATA_B0,
                                  bus.DATA_R1, bus.DATA_G1, bus.DATA_B1};
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= S_EMPTY;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      pair_q       <= '0;
      x_q          <= '0;
      y_q          <= '0;
      vsync_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vsync_q      <= bus.VSYNC;
      frame_done_q <= hs && at_eof;
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        pair_q   <= mem_q[rd_ptr_q];
      end
      if (bus.HSYNC && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign at_sol = pix_vld && (x_q == '0);
  assign at_eol = pix_vld && (x_q == X_LAST);
  assign at_sof = at_sol && (y_q == '0);
  assign at_eof = at_eol && (y_q == Y_LAST);

  assign pix = (state_q == S_PIX1) ? pair_q[23:0] : pair_q[47:24];

  assign bus.PIX_VALID  = pix_vld;
  assign bus.PIX_R      = pix_vld ? pix[23:16] : 8'h00;
  assign bus.PIX_G      = pix_vld ? pix[15:8]  : 8'h00;
  assign bus.PIX_B      = pix_vld ? pix[7:0]   : 8'h00;
  assign bus.PIX_X      = x_q;
  assign bus.PIX_Y      = y_q;
  assign bus.PIX_SOL    = at_sol;
  assign bus.PIX_EOL    = at_eol;
  assign bus.PIX_SOF    = at_sof;
  assign bus.PIX_EOF    = at_eof;
  assign bus.FIFO_LEVEL = level_q;
  assign bus.OVERFLOW   = overflow_q;
  assign bus.FRAME_DONE = frame_done_q;
endmodule
